// File: rtl/string_cmp_sequencer.sv
// Byte-serial STRCMP/STRLEN sequencer reading 32-bit words from two FIFOs.
// Bytes within a word are consumed MSB first; the FIFOs are drained to stay job-aligned.
module string_cmp_sequencer #(
   parameter int unsigned MAX_WORDS = 4,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic                              op,
   input  logic [$clog2(MAX_WORDS*4):0]      len,
   input  logic                              abort,
   input  logic                              a_valid,
   input  logic [31:0]                       a_data,
   output logic                              a_pop,
   input  logic                              b_valid,
   input  logic [31:0]                       b_data,
   output logic                              b_pop,
   output logic                              busy,
   output logic                              done,
   output logic [31:0]                       result,
   output logic                              error
);

   localparam int unsigned MAX_BYTES = MAX_WORDS * 4;
   localparam int unsigned LW        = $clog2(MAX_BYTES) + 1;
   localparam int unsigned TW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      COMPARE = 3'd2,
      DRAIN   = 3'd3,
      FINISH  = 3'd4
   } state_t;

   state_t          state, state_n;
   logic            op_r, op_n;
   logic [LW-1:0]   len_r, len_n;
   logic [31:0]     a_word, a_word_n, b_word, b_word_n;
   logic [LW-1:0]   byte_cnt, byte_cnt_n;
   logic [LW-1:0]   word_cnt, word_cnt_n;
   logic [TW-1:0]   wait_cnt, wait_n;
   logic [31:0]     res_pend, res_pend_n;
   logic [31:0]     result_n;
   logic            error_n, done_n, busy_n;

   logic [LW-1:0]   words_total;
   logic [LW-1:0]   cnt_next;
   logic [7:0]      a_byte, b_byte;
   logic [8:0]      diff;
   logic            fifo_rdy;
   logic            term;
   logic [31:0]     term_res;
   logic            wait_expired;

   // Words owned by the job: ceil(len/4).
   assign words_total  = LW'(({1'b0, len_r} + (LW+1)'(3)) >> 2);
   assign cnt_next     = byte_cnt + LW'(1);
   assign a_byte       = a_word[{~byte_cnt[1:0], 3'b000} +: 8];
   assign b_byte       = b_word[{~byte_cnt[1:0], 3'b000} +: 8];
   assign diff         = {1'b0, a_byte} - {1'b0, b_byte};
   assign fifo_rdy     = a_valid && (op_r || b_valid);
   assign wait_expired = (wait_cnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         op_r     <= 1'b0;
         len_r    <= '0;
         a_word   <= '0;
         b_word   <= '0;
         byte_cnt <= '0;
         word_cnt <= '0;
         wait_cnt <= '0;
         res_pend <= '0;
         result   <= '0;
         error    <= 1'b0;
         done     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         op_r     <= op_n;
         len_r    <= len_n;
         a_word   <= a_word_n;
         b_word   <= b_word_n;
         byte_cnt <= byte_cnt_n;
         word_cnt <= word_cnt_n;
         wait_cnt <= wait_n;
         res_pend <= res_pend_n;
         result   <= result_n;
         error    <= error_n;
         done     <= done_n;
         busy     <= busy_n;
      end
   end

   always_comb begin
      state_n    = state;
      op_n       = op_r;
      len_n      = len_r;
      a_word_n   = a_word;
      b_word_n   = b_word;
      byte_cnt_n = byte_cnt;
      word_cnt_n = word_cnt;
      wait_n     = wait_cnt;
      res_pend_n = res_pend;
      result_n   = result;
      error_n    = error;
      a_pop      = 1'b0;
      b_pop      = 1'b0;
      term       = 1'b0;
      term_res   = '0;

      case (state)
         IDLE: begin
            if (start) begin
               op_n       = op;
               len_n      = len;
               byte_cnt_n = '0;
               word_cnt_n = '0;
               wait_n     = '0;
               error_n    = 1'b0;
               if (len == '0) begin
                  state_n  = FINISH;
                  result_n = '0;
               end else if (len > LW'(MAX_BYTES)) begin
                  state_n = FINISH;
                  error_n = 1'b1;
               end else begin
                  state_n = FETCH;
               end
            end
         end

         FETCH: begin
            if (fifo_rdy) begin
               a_pop      = 1'b1;
               b_pop      = !op_r;
               a_word_n   = a_data;
               b_word_n   = b_data;
               word_cnt_n = word_cnt + LW'(1);
               wait_n     = '0;
               state_n    = COMPARE;
            end else if (wait_expired) begin
               state_n  = FINISH;
               error_n  = 1'b1;
               result_n = '0;
            end else begin
               wait_n = wait_cnt + TW'(1);
            end
         end

         COMPARE: begin
            byte_cnt_n = cnt_next;
            if (!op_r) begin
               if (a_byte != b_byte) begin
                  term     = 1'b1;
                  term_res = {{23{diff[8]}}, diff};
               end else if ((a_byte == 8'h00) || (cnt_next == len_r)) begin
                  term = 1'b1;
               end
            end else begin
               if (a_byte == 8'h00) begin
                  term     = 1'b1;
                  term_res = 32'(byte_cnt);
               end else if (cnt_next == len_r) begin
                  term     = 1'b1;
                  term_res = 32'(cnt_next);
               end
            end

            if (term) begin
               res_pend_n = term_res;
               wait_n     = '0;
               if (word_cnt < words_total) begin
                  state_n = DRAIN;
               end else begin
                  state_n  = FINISH;
                  result_n = term_res;
               end
            end else if (byte_cnt[1:0] == 2'd3) begin
               state_n = FETCH;
            end
         end

         DRAIN: begin
            if (fifo_rdy) begin
               a_pop      = 1'b1;
               b_pop      = !op_r;
               word_cnt_n = word_cnt + LW'(1);
               wait_n     = '0;
               if (word_cnt_n == words_total) begin
                  state_n  = FINISH;
                  result_n = res_pend;
               end
            end else if (wait_expired) begin
               state_n  = FINISH;
               error_n  = 1'b1;
               result_n = '0;
            end else begin
               wait_n = wait_cnt + TW'(1);
            end
         end

         FINISH: state_n = IDLE;

         default: state_n = IDLE;
      endcase

      // Abort overrides everything: no pop, no done, outputs untouched.
      if (abort && (state != IDLE)) begin
         state_n  = IDLE;
         a_pop    = 1'b0;
         b_pop    = 1'b0;
         result_n = result;
         error_n  = error;
      end

      done_n = (state_n == FINISH);
      busy_n = (state_n != IDLE);
   end

endmodule

// File: tb/tb_string_cmp_sequencer.sv
// Scoreboard bench for string_cmp_sequencer: directed jobs push expected results,
// a negedge monitor pops and compares them on every done pulse.
module tb_string_cmp_sequencer;

   localparam int unsigned TO = 20;
   localparam int unsigned LW = 5;

   typedef struct packed {
      logic [31:0] res;
      logic        err;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          op = 1'b0;
   logic [LW-1:0] len = '0;
   logic          abort = 1'b0;
   logic          a_valid = 1'b0, b_valid = 1'b0;
   logic [31:0]   a_data = '0, b_data = '0;
   logic          a_pop, b_pop, busy, done, error;
   logic [31:0]   result;

   string_cmp_sequencer #(.MAX_WORDS(4), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .len(len), .abort(abort),
      .a_valid(a_valid), .a_data(a_data), .a_pop(a_pop),
      .b_valid(b_valid), .b_data(b_data), .b_pop(b_pop),
      .busy(busy), .done(done), .result(result), .error(error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   logic [31:0] a_q[$], b_q[$];
   bit   a_en = 1'b1, b_en = 1'b1;
   int   a_pops = 0, b_pops = 0, a_cons = 0, b_cons = 0;
   int   done_count = 0, done_cyc = 0, first_a = -1;
   int   jt = 0, a0 = 0, b0 = 0, d0 = 0;
   int   checks = 0, errors = 0;
   exp_t exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
      end
   endtask

   // Monitor: pop accounting, protocol check, scoreboard compare on done.
   always @(negedge clk) begin
      exp_t e;
      if (a_pop) begin
         a_pops++;
         if (first_a < 0) first_a = cyc;
         chk("a_pop_needs_valid", 32'(a_valid), 32'd1);
      end
      if (b_pop) begin
         b_pops++;
         chk("b_pop_needs_valid", 32'(b_valid), 32'd1);
      end
      if (done) begin
         done_count++;
         done_cyc = cyc;
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("result", result, e.res);
            chk("error", 32'(error), 32'(e.err));
         end
      end
   end

   // FIFO models: consume popped words just after the edge, then present the head.
   always begin
      @(posedge clk);
      #1;
      while (a_cons < a_pops) begin
         if (a_q.size() > 0) void'(a_q.pop_front());
         a_cons++;
      end
      while (b_cons < b_pops) begin
         if (b_q.size() > 0) void'(b_q.pop_front());
         b_cons++;
      end
      a_valid = a_en && (a_q.size() > 0);
      a_data  = (a_q.size() > 0) ? a_q[0] : 32'h0;
      b_valid = b_en && (b_q.size() > 0);
      b_data  = (b_q.size() > 0) ? b_q[0] : 32'h0;
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic expect_job(input logic [31:0] res, input logic err);
      exp_t e;
      e.res = res;
      e.err = err;
      exp_q.push_back(e);
   endtask

   task automatic issue(input logic o, input logic [LW-1:0] l);
      start   = 1'b1;
      op      = o;
      len     = l;
      jt      = cyc;
      first_a = -1;
      a0      = a_pops;
      b0      = b_pops;
      d0      = done_count;
      step();
      start   = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int i = 0;
      while ((done_count == d0) && (i < budget)) begin
         @(posedge clk);
         i++;
      end
      chk({name, "_done_seen"}, 32'(done_count != d0), 32'd1);
      step();
   endtask

   task automatic check_idle_outputs(input string name);
      chk({name, "_busy"},   32'(busy),  32'd0);
      chk({name, "_done"},   32'(done),  32'd0);
      chk({name, "_error"},  32'(error), 32'd0);
      chk({name, "_result"}, result,     32'd0);
      chk({name, "_a_pop"},  32'(a_pop), 32'd0);
      chk({name, "_b_pop"},  32'(b_pop), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #2;
      check_idle_outputs("reset");
      reset = 1'b0;
      step();

      // STRCMP equal word, start ignored while busy, pop/done latency
      a_q.push_back(32'h41424344);
      b_q.push_back(32'h41424344);
      step();
      expect_job(32'h0, 1'b0);
      issue(1'b0, LW'(4));
      chk("t1_busy", 32'(busy), 32'd1);
      step();
      step();
      start = 1'b1;
      len   = '0;
      step();
      start = 1'b0;
      wait_done("t1", 20);
      chk("t1_first_pop", 32'(first_a - jt), 32'd1);
      chk("t1_done_lat", 32'(done_cyc - jt), 32'd6);
      chk("t1_a_pops", 32'(a_pops - a0), 32'd1);
      chk("t1_b_pops", 32'(b_pops - b0), 32'd1);
      step();
      chk("t1_no_extra_done", 32'(done_count - d0), 32'd1);

      // STRCMP mismatch at byte 5: 0x46 - 0x58 = -0x12
      a_q.push_back(32'h41424344); a_q.push_back(32'h45464748);
      b_q.push_back(32'h41424344); b_q.push_back(32'h45584748);
      step();
      expect_job(32'hFFFF_FFEE, 1'b0);
      issue(1'b0, LW'(8));
      wait_done("t2", 30);
      chk("t2_a_pops", 32'(a_pops - a0), 32'd2);
      chk("t2_b_pops", 32'(b_pops - b0), 32'd2);

      // Reset while DRAIN waits for words that never come
      a_q.push_back(32'h0011_2233);
      step();
      issue(1'b1, LW'(16));
      step();
      step();
      chk("rst_busy_in_drain", 32'(busy), 32'd1);
      step();
      reset = 1'b1;
      #1;
      check_idle_outputs("midjob_reset");
      step();
      reset = 1'b0;
      a_q.delete();
      b_q.delete();
      step();
      chk("rst_no_done", 32'(done_count - d0), 32'd0);

      // STRLEN stops at NUL after 2 bytes, drains the other 2 words
      a_q.push_back(32'h6162_0000);
      a_q.push_back(32'h1111_1111);
      a_q.push_back(32'h2222_2222);
      step();
      expect_job(32'd2, 1'b0);
      issue(1'b1, LW'(12));
      wait_done("t3", 40);
      chk("t3_a_pops", 32'(a_pops - a0), 32'd3);
      chk("t3_b_pops", 32'(b_pops - b0), 32'd0);
      chk("t3_a_fifo_empty", 32'(a_q.size()), 32'd0);

      // len beyond capacity: immediate error, result held
      expect_job(32'd2, 1'b1);
      issue(1'b0, LW'(20));
      wait_done("big", 5);
      chk("big_done_lat", 32'(done_cyc - jt), 32'd1);
      chk("big_a_pops", 32'(a_pops - a0), 32'd0);

      // Abort during the second COMPARE cycle
      a_q.push_back(32'h41424344); a_q.push_back(32'h45464748);
      b_q.push_back(32'h41424344); b_q.push_back(32'h45464748);
      step();
      issue(1'b0, LW'(8));
      step();
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      repeat (4) step();
      chk("abort_no_done", 32'(done_count - d0), 32'd0);
      chk("abort_a_pops", 32'(a_pops - a0), 32'd1);
      chk("abort_result_held", result, 32'd2);
      a_q.delete();
      b_q.delete();
      step();

      // len = 0 job after abort
      expect_job(32'h0, 1'b0);
      issue(1'b0, LW'(0));
      wait_done("len0", 5);
      chk("len0_done_lat", 32'(done_cyc - jt), 32'd1);
      chk("len0_a_pops", 32'(a_pops - a0), 32'd0);

      // Timeout: B never valid
      b_en = 1'b0;
      a_q.push_back(32'h41424344);
      step();
      expect_job(32'h0, 1'b1);
      issue(1'b0, LW'(4));
      wait_done("to", TO + 10);
      chk("to_latency_window",
          32'(((done_cyc - jt) >= int'(TO)) && ((done_cyc - jt) <= int'(TO) + 2)), 32'd1);
      chk("to_a_pops", 32'(a_pops - a0), 32'd0);
      chk("to_b_pops", 32'(b_pops - b0), 32'd0);
      a_q.delete();
      b_en = 1'b1;
      step();

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/string_cmp_sequencer.md
STRING_CMP_SEQUENCER -- requirements
Module: string_cmp_sequencer

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 4, meaning the maximum number of 32-bit words per string job.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles spent waiting for FIFO data before a job aborts with an error.
REQ-003 SHALL have port clk, input, 1 bit: clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: job request, sampled in IDLE only.
REQ-006 SHALL have port op, input, 1 bit: 0 = STRCMP(A,B), 1 = STRLEN(A); sampled with start.
REQ-007 SHALL have port len, input, $clog2(MAX_WORDS*4)+1 bits: job length in bytes; sampled with start.
REQ-008 SHALL have port abort, input, 1 bit: cancels the current job.
REQ-009 SHALL have ports a_valid (input, 1), a_data (input, 32) and a_pop (output, 1): FIFO A read port; a_data is valid while a_valid is high.
REQ-010 SHALL have ports b_valid (input, 1), b_data (input, 32) and b_pop (output, 1): FIFO B read port, same protocol as FIFO A.
REQ-011 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse at job end.
REQ-013 SHALL have port result, output, 32 bits: job result, held until the next job's done.
REQ-014 SHALL have port error, output, 1 bit: qualifies done; high on timeout or len > MAX_WORDS*4.

Function
REQ-015 SHALL implement states IDLE, FETCH, COMPARE, DRAIN, FINISH.
REQ-016 SHALL leave IDLE only on start=1; start in any other state SHALL be ignored.
REQ-017 SHALL, for len=0, go IDLE->FINISH with result=0, error=0 and no pops.
REQ-018 SHALL, for len > MAX_WORDS*4, go IDLE->FINISH with error=1, result unchanged and no pops.
REQ-019 SHALL, in FETCH, wait for a_valid (and b_valid when op=0); when ready, assert a_pop (and b_pop) for exactly one cycle, latch the data and enter COMPARE.
REQ-020 SHALL never assert a pop while the matching valid is low; b_pop SHALL stay 0 when op=1.
REQ-021 SHALL order bytes within a word as byte0 = bits[31:24] through byte3 = bits[7:0].
REQ-022 SHALL, in COMPARE, process one byte per cycle and keep a running byte count.
REQ-023 SHALL, for STRCMP, terminate on byte mismatch with result = sign-extended (A_byte - B_byte), computed as 9-bit signed.
REQ-024 SHALL, for STRCMP, terminate on equal NUL bytes, or on count reaching len, with result=0.
REQ-025 SHALL, for STRLEN, terminate on a NUL byte, or on count reaching len, with result = number of non-NUL bytes counted.
REQ-026 SHALL, after byte3 of a word when not terminated, return to FETCH.
REQ-027 SHALL, on early termination with words of the job (ceil(len/4) total) still unpopped, enter DRAIN; otherwise enter FINISH.
REQ-028 SHALL, in DRAIN, pop one word per cycle from each active FIFO when valid, until ceil(len/4) words have been consumed, so the FIFOs stay job-aligned.
REQ-029 SHALL run a wait counter in FETCH/DRAIN that resets on each pop; on reaching TIMEOUT it SHALL go to FINISH with error=1 and result=0.
REQ-030 SHALL, in FINISH, pulse done for one cycle and return to IDLE; error SHALL be valid in the same cycle and cleared at the next start.
REQ-031 SHALL, on abort in any non-IDLE state, go to IDLE next cycle with no done, no further pops and result unchanged; abort has priority over all other transitions.

Reset
REQ-032 SHALL, on reset at any time including mid-job, immediately force state=IDLE; busy, done, error, a_pop and b_pop to 0; result=0; and all counters to 0.

Verification
REQ-033 Bench SHALL cover: STRCMP, len=4, A=B=0x41424344, FIFOs always valid, start at cycle T -> pops at T+1, done at T+6, result=0, error=0.
REQ-034 Bench SHALL cover: STRCMP, len=8, A={0x41424344,0x45464748}, B={0x41424344,0x45584748} -> mismatch at byte 5, result=0xFFFFFFEE, exactly 2 pops per FIFO.
REQ-035 Bench SHALL cover: STRLEN, len=12, A={0x61620000,x,x} -> result=2, DRAIN pops the 2 remaining words, b_pop never asserted.
REQ-036 Bench SHALL cover: STRCMP, len=4, b_valid held low -> done with error=1 after TIMEOUT cycles, zero pops.
REQ-037 Bench SHALL cover: abort two cycles into COMPARE -> IDLE next cycle, no done pulse; a following len=0 job gives done with result=0.
REQ-038 Bench SHALL cover: reset asserted mid-DRAIN -> all outputs 0 immediately; start asserted while busy -> ignored.
